// File: rtl/sdp_ram_pkg.sv
// Shared types for the simple dual-port byte-enable RAM.
//   rdw_mode_e : policy for a same-address read and write at one edge
//                RDW_OLD_DATA returns the pre-write word,
//                RDW_NEW_DATA returns enabled lanes from the write data.
package sdp_ram_pkg;
  typedef enum logic {RDW_OLD_DATA, RDW_NEW_DATA} rdw_mode_e;
endpackage

// File: rtl/sdp_be_ram_array.sv
// Byte-lane-enabled storage array with one write port and one registered
// read port. There is no reset, so the array can map onto MLAB blocks.
// A read and a write to one address at one edge return the old word.
// Ports:
//   clk_i    : clock
//   wr_en    : write strobe (already qualified with reset by the parent)
//   addr_wr  : write address
//   data_wr  : write data
//   be_wr    : per-lane write enables
//   rd_en    : read strobe; data_rd updates only when it is set
//   addr_rd  : read address
//   data_rd  : registered read data
module sdp_be_ram_array #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ADDR_WIDTH = 4,
  parameter int P_BYTE_WIDTH = 8
) (
  input  logic                                 clk_i,
  input  logic                                 wr_en,
  input  logic [P_ADDR_WIDTH-1:0]              addr_wr,
  input  logic [P_DATA_WIDTH-1:0]              data_wr,
  input  logic [P_DATA_WIDTH/P_BYTE_WIDTH-1:0] be_wr,
  input  logic                                 rd_en,
  input  logic [P_ADDR_WIDTH-1:0]              addr_rd,
  output logic [P_DATA_WIDTH-1:0]              data_rd
);
  localparam int NB    = P_DATA_WIDTH / P_BYTE_WIDTH;
  localparam int DEPTH = 2 ** P_ADDR_WIDTH;

  (* ramstyle = "MLAB" *) logic [NB-1:0][P_BYTE_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NB; k++) begin
      if (wr_en && be_wr[k]) mem[addr_wr][k] <= data_wr[k*P_BYTE_WIDTH +: P_BYTE_WIDTH];
    end
    // NBA semantics give old data on a same-address collision.
    if (rd_en) data_rd <= mem[addr_rd];
  end
endmodule

// File: rtl/sdp_be_pipe_ram.sv
// Simple dual-port RAM with byte-lane write enables, selectable read
// latency (1 or 2) and selectable same-address read-during-write policy.
// A read accepted at edge t shows valid_rd_o/data_rd_o in the cycle that
// ends with edge t+P_RD_LATENCY. data_rd_o holds between pulses.
// Ports:
//   clk_i, rst_i           : clock, synchronous active-high reset
//   wr_i, addr_wr_i,
//   data_wr_i, be_wr_i     : write request with lane enables
//   rd_i, addr_rd_i        : read request
//   data_rd_o, valid_rd_o  : read data and its one-cycle valid pulse
module sdp_be_pipe_ram
  import sdp_ram_pkg::*;
#(
  parameter int        P_DATA_WIDTH = 32,
  parameter int        P_ADDR_WIDTH = 4,
  parameter int        P_BYTE_WIDTH = 8,
  parameter int        P_RD_LATENCY = 1,
  parameter rdw_mode_e P_RDW_MODE   = RDW_OLD_DATA
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 wr_i,
  input  logic [P_ADDR_WIDTH-1:0]              addr_wr_i,
  input  logic [P_DATA_WIDTH-1:0]              data_wr_i,
  input  logic [P_DATA_WIDTH/P_BYTE_WIDTH-1:0] be_wr_i,
  input  logic                                 rd_i,
  input  logic [P_ADDR_WIDTH-1:0]              addr_rd_i,
  output logic [P_DATA_WIDTH-1:0]              data_rd_o,
  output logic                                 valid_rd_o
);
  localparam int NB = P_DATA_WIDTH / P_BYTE_WIDTH;
  localparam int BW = P_BYTE_WIDTH;

  if (P_DATA_WIDTH % P_BYTE_WIDTH != 0) begin : g_bad_bw
    $error("P_DATA_WIDTH must be a multiple of P_BYTE_WIDTH");
  end
  if (P_RD_LATENCY != 1 && P_RD_LATENCY != 2) begin : g_bad_lat
    $error("P_RD_LATENCY must be 1 or 2");
  end

  logic                    wr_en, rd_en;
  logic [P_RD_LATENCY:1]   vld_pipe;
  logic [P_DATA_WIDTH-1:0] ram_q, s1_data, dq;

  assign wr_en = wr_i & ~rst_i;
  assign rd_en = rd_i & ~rst_i;

  sdp_be_ram_array #(
    .P_DATA_WIDTH(P_DATA_WIDTH),
    .P_ADDR_WIDTH(P_ADDR_WIDTH),
    .P_BYTE_WIDTH(P_BYTE_WIDTH)
  ) u_array (
    .clk_i  (clk_i),
    .wr_en  (wr_en),
    .addr_wr(addr_wr_i),
    .data_wr(data_wr_i),
    .be_wr  (be_wr_i),
    .rd_en  (rd_en),
    .addr_rd(addr_rd_i),
    .data_rd(ram_q)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_en;
      for (int i = 2; i <= P_RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  if (P_RDW_MODE == RDW_NEW_DATA) begin : g_new
    // Capture the colliding write alongside the read so the merge can
    // patch the array's old-data word one cycle later.
    logic                    fwd_hit;
    logic [NB-1:0]           fwd_be;
    logic [P_DATA_WIDTH-1:0] fwd_data, merged;

    always_ff @(posedge clk_i) begin
      if (rst_i) fwd_hit <= 1'b0;
      else       fwd_hit <= wr_en & rd_en & (addr_wr_i == addr_rd_i);
      fwd_be   <= be_wr_i;
      fwd_data <= data_wr_i;
    end

    always_comb begin
      merged = ram_q;
      for (int k = 0; k < NB; k++) begin
        if (fwd_hit && fwd_be[k]) merged[k*BW +: BW] = fwd_data[k*BW +: BW];
      end
    end
    assign s1_data = merged;
  end else begin : g_old
    assign s1_data = ram_q;
  end

  // dq is the second stage for latency 2, and the hold register that keeps
  // the last result on the output between pulses for latency 1.
  always_ff @(posedge clk_i) begin
    if (rst_i)            dq <= '0;
    else if (vld_pipe[1]) dq <= s1_data;
  end

  if (P_RD_LATENCY == 1) begin : g_lat1
    assign data_rd_o = vld_pipe[1] ? s1_data : dq;
  end else begin : g_lat2
    assign data_rd_o = dq;
  end

  assign valid_rd_o = vld_pipe[P_RD_LATENCY];
endmodule
